// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: converts a valid/ready request port into APB4 SETUP/ACCESS transfers
// with a single-cycle response pulse and an optional ACCESS-phase wait timeout.
module apb4_master_bridge #(
  parameter int PADDR_SIZE = 32,
  parameter int PDATA_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PADDR_SIZE-1:0]   req_addr,
  input  logic [PDATA_SIZE-1:0]   req_wdata,
  input  logic [PDATA_SIZE/8-1:0] req_be,
  input  logic [2:0]              req_prot,
  output logic                    rsp_valid,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
  logic [1:0] state;
  logic       tmo, accept, done;
  assign req_ready = state == IDLE || (state == ACCESS && PREADY);
  assign accept    = req_valid && req_ready;
  assign done      = state == ACCESS && (PREADY || tmo);
  generate
    if (TIMEOUT > 0) begin : g_tmo
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] cnt;
      always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) cnt <= '0;
        else if (state == SETUP) cnt <= '0;
        else if (state == ACCESS && !PREADY) cnt <= cnt + 1'b1;
      assign tmo = cnt == CW'(TIMEOUT) && !PREADY;
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end
  endgenerate
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err     <= PREADY ? PSLVERR : 1'b1;
        rsp_timeout <= !PREADY;
        rsp_rdata   <= PREADY && !PWRITE ? PRDATA : '0;
      end
      // a request accepted on the completing ACCESS cycle goes straight to SETUP with PSEL held
      if (accept) begin
        state   <= SETUP;
        PSEL    <= 1'b1;
        PENABLE <= 1'b0;
        PWRITE  <= req_write;
        PADDR   <= req_addr;
        PWDATA  <= req_wdata;
        PSTRB   <= req_write ? req_be : '0;
        PPROT   <= req_prot;
      end else if (state == SETUP) begin
        state   <= ACCESS;
        PENABLE <= 1'b1;
      end else if (done) begin
        state   <= IDLE;
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: randomized requests against an APB slave model that predicts each
// transfer's field values, ACCESS length, response timing and response contents.
module tb_apb4_master_bridge;
  localparam int TMO = 4;
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [2:0]  p;
  } req_t;
  logic        clk = 1'b0;
  logic        PRESET, req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  int          n_chk = 0, n_fail = 0;
  req_t        exp_req[$];
  int          f_cnt = 0, f_wait = 0;
  logic        f_err = 1'b0;
  logic [31:0] f_rd = '0;
  logic        in_xfer, due, e_err, e_tmo, s_err, last_err, last_tmo;
  logic [31:0] e_rdata, s_rd, last_rdata;
  int          w_n, acc, phase;
  req_t        cur;

  apb4_master_bridge #(.PADDR_SIZE(32), .PDATA_SIZE(32), .TIMEOUT(TMO)) dut (
    .PCLK(clk), .PRESET(PRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // called just after a falling edge; returns just after the falling edge following the handshake
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [2:0] p);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be; req_prot = p;
    #3;
    while (!req_ready && n < 60) begin
      @(negedge clk); #3; n++;
    end
    if (req_ready) exp_req.push_back('{w, a, d, w ? be : 4'h0, p});
    else check("req_handshake", req_ready, 1'b1);
    @(negedge clk);
  endtask

  // APB slave model and response scoreboard
  initial begin
    in_xfer = 0; due = 0; last_rdata = '0; last_err = 0; last_tmo = 0;
    forever begin
      @(negedge clk);
      if (PRESET) begin
        in_xfer = 0; due = 0; PREADY = 0; exp_req.delete();
        last_rdata = '0; last_err = 0; last_tmo = 0;
        continue;
      end
      check("rsp_valid", rsp_valid, due);
      if (due) begin
        last_rdata = e_rdata; last_err = e_err; last_tmo = e_tmo;
        check("penable_after_done", PENABLE, 1'b0);
        check("psel_after_done", PSEL, exp_req.size() != 0);
        due = 0;
      end
      check("rsp_rdata", rsp_rdata, last_rdata);
      check("rsp_err", rsp_err, last_err);
      check("rsp_timeout", rsp_timeout, last_tmo);
      PREADY = 0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      phase = 0;
      if (PSEL && !PENABLE) begin
        phase = 1;
        check("setup_pending", exp_req.size() != 0, 1'b1);
        if (exp_req.size() != 0) begin
          cur = exp_req.pop_front();
          check("setup_fields", {PWRITE, PADDR, PWDATA, PSTRB, PPROT}, cur);
        end
        in_xfer = 1; acc = 0;
        if (f_cnt > 0) begin
          w_n = f_wait; s_err = f_err; s_rd = f_rd; f_cnt--;
        end else begin
          w_n = $urandom_range(0, 6); s_err = $urandom_range(0, 3) == 0; s_rd = $urandom;
        end
      end else if (PSEL && PENABLE) begin
        phase = 2;
        check("access_in_xfer", in_xfer, 1'b1);
        check("access_stable", {PWRITE, PADDR, PWDATA, PSTRB, PPROT}, cur);
        PREADY = acc >= w_n;
        if (PREADY) begin
          PSLVERR = s_err; PRDATA = s_rd;
        end
        // more than TMO wait cycles means the bridge aborts on ACCESS cycle TMO
        if (acc == (w_n > TMO ? TMO : w_n)) begin
          due = 1; in_xfer = 0;
          e_tmo = w_n > TMO;
          e_err = e_tmo ? 1'b1 : s_err;
          e_rdata = (e_tmo || cur.w) ? 32'h0 : s_rd;
        end
        acc++;
      end
      #1 check("req_ready", req_ready, phase == 0 ? 1'b1 : phase == 1 ? 1'b0 : PREADY);
    end
  end

  initial begin
    int n;
    PRESET = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_prot = '0; PREADY = 0; PRDATA = '0; PSLVERR = 0;
    #2;
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pstrb", PSTRB, 4'h0);
    check("rst_pprot", PPROT, 3'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
    check("rst_req_ready", req_ready, 1'b1);
    #10 PRESET = 0;
    @(negedge clk);
    f_cnt = 1; f_wait = 0; f_err = 0;
    send(1, 32'h1000, 32'hDEADBEEF, 4'hF, 3'b000);
    req_valid = 0; repeat (3) @(negedge clk);
    f_cnt = 1; f_wait = 2; f_rd = 32'h12345678;
    send(0, 32'h2004, 32'h0, 4'hF, 3'b010);
    req_valid = 0; repeat (5) @(negedge clk);
    f_cnt = 3; f_wait = 0;
    for (int i = 0; i < 3; i++) send(1, 32'h3000 + 4 * i, 32'hA0 + i, 4'h3, 3'b001);
    req_valid = 0; repeat (3) @(negedge clk);
    f_cnt = 1; f_wait = 1; f_err = 1; f_rd = 32'hCAFE0001;
    send(0, 32'h4000, 32'h0, 4'h0, 3'b100);
    req_valid = 0; repeat (4) @(negedge clk);
    f_cnt = 1; f_wait = TMO; f_err = 0; f_rd = 32'h55AA55AA;
    send(0, 32'h5000, 32'h0, 4'h0, 3'b000);
    req_valid = 0; repeat (8) @(negedge clk);
    f_cnt = 1; f_wait = 20;
    send(0, 32'h6000, 32'h0, 4'h0, 3'b011);
    send(1, 32'h6004, 32'h77, 4'h1, 3'b000);
    req_valid = 0; repeat (4) @(negedge clk);
    f_cnt = 1; f_wait = 30;
    send(1, 32'h7000, 32'h99, 4'hF, 3'b000);
    req_valid = 0; n = 0;
    while (!(PSEL && PENABLE) && n < 10) begin @(negedge clk); n++; end
    check("rst_reach_access", PSEL && PENABLE, 1'b1);
    @(negedge clk);
    #2 PRESET = 1;
    #1 check("rst_async_psel", {PSEL, PENABLE}, 2'b00);
    @(negedge clk); @(negedge clk);
    #2 PRESET = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
        send(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom));
      end
    end
    req_valid = 0;
    repeat (20) @(negedge clk);
    check("drain_pending", exp_req.size(), 0);
    check("drain_due", due, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
